// File: rtl/mant_mul_arbiter_if.sv
// Bundle of the two requester channels and the tagged result channel
// around the shared mantissa multiplier.
interface mant_mul_arbiter_if #(
  parameter int WIDTH = 24
);
  logic               req0_valid;
  logic               req0_ready;
  logic [WIDTH-1:0]   req0_a;
  logic [WIDTH-1:0]   req0_b;
  logic               req1_valid;
  logic               req1_ready;
  logic [WIDTH-1:0]   req1_a;
  logic [WIDTH-1:0]   req1_b;
  logic               res_valid;
  logic               res_ready;
  logic               res_id;
  logic [2*WIDTH-1:0] res_p;
  logic               busy;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_id, res_p, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_id, res_p, busy
  );
endinterface

// File: rtl/mant_mul_arbiter.sv
// Round-robin sharing of one unsigned WIDTHxWIDTH array multiplier between
// two requesters; operand stage and product stage, result tagged with owner ID.
module mant_mul_arbiter #(
  parameter int WIDTH = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  mant_mul_arbiter_if.slave  bus
);
  logic               s1_valid_reg;
  logic               s1_id_reg;
  logic [WIDTH-1:0]   s1_a_reg;
  logic [WIDTH-1:0]   s1_b_reg;
  logic               res_valid_reg;
  logic               res_id_reg;
  logic [2*WIDTH-1:0] res_p_reg;
  logic               last_grant_reg;

  logic               adv1;
  logic               adv2;
  logic               any_req;
  logic               grant_id;
  logic [2*WIDTH-1:0] product;

  assign adv2    = !res_valid_reg || bus.res_ready;
  assign adv1    = !s1_valid_reg || adv2;
  assign any_req = bus.req0_valid || bus.req1_valid;

  // On a tie the requester that did not win last time gets the slot.
  always_comb begin
    grant_id = 1'b0;
    if (bus.req0_valid && bus.req1_valid)
      grant_id = ~last_grant_reg;
    else if (bus.req1_valid)
      grant_id = 1'b1;
  end

  // rst_n gates the readys so nothing is acknowledged while reset is held.
  assign bus.req0_ready = rst_n && adv1 && bus.req0_valid && !grant_id;
  assign bus.req1_ready = rst_n && adv1 && bus.req1_valid &&  grant_id;

  // Shift-and-add array: row gi adds A<<gi when bit gi of B is set.
  logic [2*WIDTH-1:0] pp_sum [0:WIDTH];
  assign pp_sum[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_row
      assign pp_sum[gi+1] = pp_sum[gi] +
        (s1_b_reg[gi] ? ({{WIDTH{1'b0}}, s1_a_reg} << gi) : {2*WIDTH{1'b0}});
    end
  endgenerate

  assign product = pp_sum[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg   <= 1'b0;
      s1_id_reg      <= 1'b0;
      s1_a_reg       <= '0;
      s1_b_reg       <= '0;
      last_grant_reg <= 1'b1;
    end else if (adv1) begin
      s1_valid_reg <= any_req;
      if (any_req) begin
        s1_id_reg      <= grant_id;
        s1_a_reg       <= grant_id ? bus.req1_a : bus.req0_a;
        s1_b_reg       <= grant_id ? bus.req1_b : bus.req0_b;
        last_grant_reg <= grant_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_reg <= 1'b0;
      res_id_reg    <= 1'b0;
      res_p_reg     <= '0;
    end else if (adv2) begin
      res_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        res_id_reg <= s1_id_reg;
        res_p_reg  <= product;
      end
    end
  end

  assign bus.res_valid = res_valid_reg;
  assign bus.res_id    = res_id_reg;
  assign bus.res_p     = res_p_reg;
  assign bus.busy      = s1_valid_reg || res_valid_reg;
endmodule

// File: tb/tb_mant_mul_arbiter.sv
// Directed bench for mant_mul_arbiter: stimulus queues feed the requesters,
// a scoreboard queue holds hand-computed results checked by a separate monitor.
module tb_mant_mul_arbiter;
  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [47:0] p;
  } vec_t;

  typedef struct {
    logic        id;
    logic [47:0] p;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mant_mul_arbiter_if #(.WIDTH(24)) bus ();

  mant_mul_arbiter #(.WIDTH(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  vec_t vec0[$];
  vec_t vec1[$];
  exp_t sb[$];
  int   glog[$];
  int   checks    = 0;
  int   failures  = 0;
  int   res_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a result shown at the falling edge is consumed at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=id%0d p=0x%0h required=none",
                 bus.res_id, bus.res_p);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_id", 64'(bus.res_id), 64'(e.id));
        check("res_p", 64'(bus.res_p), 64'(e.p));
        $display("result id=%0d p=0x%0h expected id=%0d p=0x%0h",
                 bus.res_id, bus.res_p, e.id, e.p);
      end
      res_count++;
    end
  end

  task automatic add0(input logic [23:0] a, input logic [23:0] b, input logic [47:0] p);
    vec0.push_back('{a: a, b: b, p: p});
  endtask

  task automatic add1(input logic [23:0] a, input logic [23:0] b, input logic [47:0] p);
    vec1.push_back('{a: a, b: b, p: p});
  endtask

  task automatic drive();
    bus.req0_valid = (vec0.size() != 0);
    bus.req1_valid = (vec1.size() != 0);
    if (vec0.size() != 0) begin
      bus.req0_a = vec0[0].a;
      bus.req0_b = vec0[0].b;
    end
    if (vec1.size() != 0) begin
      bus.req1_a = vec1[0].a;
      bus.req1_b = vec1[0].b;
    end
  endtask

  // One clock: present queued operands, record the handshake, advance past the edge.
  task automatic cycle();
    logic t0, t1;
    drive();
    @(negedge clk);
    t0 = bus.req0_ready;
    t1 = bus.req1_ready;
    if (t0 && t1)
      check("one_ready", 64'(t0 && t1), 64'd0);
    if (t0 && vec0.size() != 0) begin
      sb.push_back('{id: 1'b0, p: vec0[0].p});
      glog.push_back(0);
    end
    if (t1 && vec1.size() != 0) begin
      sb.push_back('{id: 1'b1, p: vec1[0].p});
      glog.push_back(1);
    end
    @(posedge clk);
    #1;
    if (t0 && vec0.size() != 0) void'(vec0.pop_front());
    if (t1 && vec1.size() != 0) void'(vec1.pop_front());
    drive();
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      cycle();
      done = (vec0.size() == 0) && (vec1.size() == 0) && (sb.size() == 0);
    end
    check("drain_done", 64'(done), 64'd1);
  endtask

  initial begin
    int g0, rc0;
    rst_n          = 1'b0;
    bus.res_ready  = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_a     = 24'h1;
    bus.req0_b     = 24'h1;
    bus.req1_a     = 24'h1;
    bus.req1_b     = 24'h1;

    // Reset state, with both requesters pushing.
    #12;
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_res_p", 64'(bus.res_p), 64'd0);
    check("rst_res_id", 64'(bus.res_id), 64'd0);
    check("rst_req0_ready", 64'(bus.req0_ready), 64'd0);
    check("rst_req1_ready", 64'(bus.req1_ready), 64'd0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request and latency.
    bus.res_ready = 1'b1;
    add0(24'h800000, 24'hC00000, 48'h600000000000);
    cycle();
    check("single_grant", 64'(glog.size()), 64'd1);
    check("single_s2_empty", 64'(bus.res_valid), 64'd0);
    cycle();
    check("single_res_valid", 64'(bus.res_valid), 64'd1);
    check("single_busy", 64'(bus.busy), 64'd1);
    cycle();
    check("single_busy_after", 64'(bus.busy), 64'd0);
    check("single_count", 64'(res_count), 64'd1);

    // Boundary operands on requester 1.
    add1(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);
    add1(24'h000000, 24'hABCDEF, 48'h0);
    drain();

    // Tie: alternating grants, back-to-back results.
    g0  = glog.size();
    rc0 = res_count;
    add0(24'd3, 24'd5, 48'd15);
    add0(24'd3, 24'd5, 48'd15);
    add1(24'd7, 24'd11, 48'd77);
    add1(24'd7, 24'd11, 48'd77);
    repeat (6) cycle();
    check("tie_grant0", 64'(glog[g0]), 64'd0);
    check("tie_grant1", 64'(glog[g0+1]), 64'd1);
    check("tie_grant2", 64'(glog[g0+2]), 64'd0);
    check("tie_grant3", 64'(glog[g0+3]), 64'd1);
    check("tie_back_to_back", 64'(res_count - rc0), 64'd4);

    // Backpressure: only two accepted while the result is stalled.
    bus.res_ready = 1'b0;
    g0 = glog.size();
    add0(24'd1, 24'd2, 48'd2);
    add0(24'd2, 24'd2, 48'd4);
    add0(24'd3, 24'd2, 48'd6);
    add0(24'd4, 24'd2, 48'd8);
    repeat (4) cycle();
    check("bp_accepted", 64'(glog.size() - g0), 64'd2);
    check("bp_req0_ready", 64'(bus.req0_ready), 64'd0);
    check("bp_res_valid", 64'(bus.res_valid), 64'd1);
    check("bp_res_p", 64'(bus.res_p), 64'd2);
    repeat (2) cycle();
    check("bp_res_p_hold", 64'(bus.res_p), 64'd2);
    check("bp_res_id_hold", 64'(bus.res_id), 64'd0);
    bus.res_ready = 1'b1;
    drain();

    // Requester 1 streaming; a single req0 gets in on the next grant.
    add1(24'h10, 24'h10, 48'h100);
    add1(24'h10, 24'h10, 48'h100);
    add1(24'h10, 24'h10, 48'h100);
    add1(24'h10, 24'h10, 48'h100);
    cycle();
    add0(24'h123, 24'h2, 48'h246);
    g0 = glog.size();
    cycle();
    check("starve_grant", 64'(glog[g0]), 64'd0);
    drain();

    // Asynchronous reset with two transactions in flight.
    bus.res_ready = 1'b0;
    g0 = glog.size();
    add0(24'd5, 24'd5, 48'd25);
    add0(24'd5, 24'd5, 48'd25);
    repeat (2) cycle();
    check("mid_accepted", 64'(glog.size() - g0), 64'd2);
    #2 rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    check("mid_res_valid", 64'(bus.res_valid), 64'd0);
    check("mid_busy", 64'(bus.busy), 64'd0);
    check("mid_req0_ready", 64'(bus.req0_ready), 64'd0);
    check("mid_req1_ready", 64'(bus.req1_ready), 64'd0);
    sb.delete();
    vec0.delete();
    vec1.delete();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b1;
    rc0 = res_count;
    g0  = glog.size();
    add0(24'd9, 24'd9, 48'd81);
    add1(24'd6, 24'd7, 48'd42);
    cycle();
    check("post_rst_grant", 64'(glog[g0]), 64'd0);
    drain();
    check("post_rst_count", 64'(res_count - rc0), 64'd2);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mant_mul_arbiter.md
Name: mant_mul_arbiter

Overview:
- Shares one 24x24 unsigned mantissa multiplier between two requesters: requester 0 is the FP multiply path, requester 1 is the FP divide/iteration path.
- Arbitration is round-robin.
- Operands and product are registered in a 2-stage pipeline around the combinational array multiplier instance.
- Each result is returned with a requester ID tag over a valid/ready handshake with backpressure.

Parameters:
- WIDTH, 24, operand width. The product is 2*WIDTH bits. The block is verified only at 24.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req0_valid  input  1  requester 0 has operands
- req0_ready  output  1  requester 0 operands accepted this cycle
- req0_a  input  WIDTH  requester 0 operand A
- req0_b  input  WIDTH  requester 0 operand B
- req1_valid  input  1  requester 1 has operands
- req1_ready  output  1  requester 1 operands accepted this cycle
- req1_a  input  WIDTH  requester 1 operand A
- req1_b  input  WIDTH  requester 1 operand B
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_id  output  1  requester that owns the result
- res_p  output  2*WIDTH  product A*B
- busy  output  1  a transaction is in flight

Behaviour:
- Reset (rst_n low, asynchronous):
  - s1_valid=0, res_valid=0, res_id=0, res_p=0.
  - Stage-1 operand/ID registers = 0.
  - Round-robin pointer last_grant=1, so requester 0 wins the first tie.
  - busy=0, both readys=0 while in reset.
  - Any in-flight transaction is dropped with no result. Requesters must re-present operands.
- Pipeline:
  - Stage 1 holds s1_valid, s1_id, s1_a, s1_b and feeds the combinational multiplier.
  - Stage 2 holds res_valid, res_id, res_p.
- Advance rules:
  - adv2 = !res_valid || res_ready.
  - adv1 = !s1_valid || adv2.
- Stage 2 on adv2: res_valid <= s1_valid. If s1_valid, load res_p = s1_a*s1_b (full 48-bit, no truncation/rounding) and res_id = s1_id.
- Stage 2 when !adv2: hold all stage-2 registers unchanged. res_p/res_id stay stable while res_valid && !res_ready.
- Arbitration (combinational, evaluated only when adv1=1):
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant the requester != last_grant.
  - reqX_ready = adv1 && granted(X). At most one ready is high per cycle.
  - Ready depends combinationally on valid and res_ready. A requester must not make valid depend on ready.
- On a handshake: stage 1 loads operands, s1_id=X, s1_valid=1, and last_grant<=X.
- adv1 with no request: s1_valid<=0.
- last_grant changes only on a handshake.
- Latency: handshake at edge N gives res_valid high after edge N+1, assuming no stall. The result is consumed at edge N+2 if res_ready=1.
- Throughput: one result per cycle sustained when res_ready=1.
- Stalls:
  - res_ready low with both stages full: both readys = 0 and nothing is lost or overwritten.
  - Stall with stage 1 empty: one more request may be accepted into stage 1.
- Requesters must hold valid and operands stable until ready. The block does not check this.
- busy = s1_valid || res_valid.
- Ordering: results leave in acceptance order. The ID is carried with the operands, never recomputed.
- Edge operands: zero operand gives 0. FFFFFF*FFFFFF = FFFFFE000001, no overflow possible.

Test Plan:
- Reset then single request: req0 A=0x800000, B=0xC00000, res_ready=1 -> req0_ready=1 that cycle; two edges later res_valid=1, res_id=0, res_p=0x600000000000; busy=0 afterwards.
- Tie / round-robin: both valid continuously, req0 A=3 B=5, req1 A=7 B=11, res_ready=1 -> grants 0,1,0,1; results 15(id0), 77(id1), 15, 77 back-to-back, one per cycle.
- Backpressure: res_ready=0, req0 issues four requests A=1..4, B=2 -> exactly two accepted, then both readys 0; res_p holds 2, unchanged until res_ready=1; then results 2,4,6,8 in order, none lost or duplicated.
- Boundary operands: req1 A=B=0xFFFFFF -> res_p=0xFFFFFE000001, id1. Then A=0, B=0xABCDEF -> res_p=0.
- Reset mid-flight: accept two requests, assert rst_n=0 asynchronously between edges -> res_valid, busy, readys drop immediately. After release, first tie grants requester 0 and no stale result appears.
- Single requester starvation check: req1 always valid, req0 asserted once -> req0 granted at the next accepting cycle (within 1 grant) with res_id=0.
